// File: rtl/uart_pkg.sv
// Shared UART types and helpers: parity modes, receiver FSM states and the
// expected-parity-bit function used by the receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int DEFAULT_BAUD_DIV = 2604;

  // Returns the parity bit that makes the frame correct; narrower words are
  // passed zero-extended, which leaves the XOR unchanged.
  function automatic logic calc_parity(input logic [7:0] data, input parity_e mode);
    logic p;
    p = ^data;
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous idle-high serial line, plus a
// falling-edge strobe on the synchronised value. All flops reset to 1 (idle).
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_sync,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rx;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rx_sync = s2;
  assign fall    = s3 & ~s2;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with valid/ready output and framing, parity and
// overrun flags. Define UART_RX_MAJVOTE_EN for 3-sample majority bit decisions.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int BAUD_DIV  = DEFAULT_BAUD_DIV,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW       = $clog2(BAUD_DIV);
  localparam int PAR_BITS = (PARITY != 0) ? 1 : 0;
  localparam int TOTAL    = DATA_BITS + PAR_BITS + STOP_BITS;
  localparam int BW       = $clog2(TOTAL + 1);

  localparam parity_e         PAR_MODE  = parity_e'(PARITY[1:0]);
  localparam logic [CW-1:0]   HALF      = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0]   FULL      = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0]   LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0]   LAST_BIT  = BW'(TOTAL - 1);

  rx_state_e              state, state_nxt;
  logic                   rx_s, fall;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   ferr_acc, perr_acc;
  logic                   tick, samp, done;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .rx      (RX),
    .rx_sync (rx_s),
    .fall    (fall)
  );

  assign tick = (cnt == '0);
  assign busy = (state != IDLE);

`ifdef UART_RX_MAJVOTE_EN
  logic v2, v1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2 <= 1'b1;
      v1 <= 1'b1;
    end else begin
      if (cnt == CW'(2)) v2 <= rx_s;
      if (cnt == CW'(1)) v1 <= rx_s;
    end
  end

  assign samp = (v2 & v1) | (v2 & rx_s) | (v1 & rx_s);
`else
  assign samp = rx_s;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:  if (fall) state_nxt = START;
      START: if (tick) state_nxt = samp ? IDLE : DATA;
      DATA:  if (tick && bit_cnt == LAST_DATA)
               state_nxt = (PARITY != 0) ? uart_pkg::PARITY : STOP;
      uart_pkg::PARITY: if (tick) state_nxt = STOP;
      STOP:  if (tick && bit_cnt == LAST_BIT) begin
               state_nxt = IDLE;
               done      = 1'b1;
             end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit timing and frame assembly: one sample per bit at count 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      ferr_acc <= 1'b0;
      perr_acc <= 1'b0;
    end else if (state == IDLE) begin
      if (fall) cnt <= HALF;
      bit_cnt  <= '0;
      ferr_acc <= 1'b0;
      perr_acc <= 1'b0;
    end else if (tick) begin
      cnt <= FULL;
      case (state)
        DATA: begin
          shreg   <= {samp, shreg[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
        uart_pkg::PARITY: begin
          perr_acc <= samp ^ calc_parity(8'(shreg), PAR_MODE);
          bit_cnt  <= bit_cnt + 1'b1;
        end
        STOP: begin
          ferr_acc <= ferr_acc | ~samp;
          bit_cnt  <= bit_cnt + 1'b1;
        end
        default: ;
      endcase
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  // Output holding register; a completion with no free slot is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else if (done && (!rx_valid || rx_ready)) begin
      rx_data    <= shreg;
      frame_err  <= ferr_acc | ~samp;
      parity_err <= perr_acc;
      rx_valid   <= 1'b1;
    end else if (done) begin
      overrun <= 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 and a 7E2 instance at BAUD_DIV=16,
// scoreboard of expected words; the glitch-in-0xFF step needs UART_RX_MAJVOTE_EN.
module tb_uart_rx_param;

  localparam int BD = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx8, rx7, rdy8, rdy7;
  logic [7:0] d8;
  logic [6:0] d7;
  logic       v8, v7, fe8, fe7, pe8, pe7, ov8, ov7, b8, b7;

  exp_t q8[$];
  exp_t q7[$];
  int   compared = 0;
  int   mism     = 0;
  int   cyc      = 0;
  int   t_start  = 0;
  int   t_valid  = 0;
  logic v8_q     = 1'b0;

  uart_rx_param #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut8 (
    .clk(clk), .rst(rst), .RX(rx8), .rx_data(d8), .rx_valid(v8), .rx_ready(rdy8),
    .frame_err(fe8), .parity_err(pe8), .overrun(ov8), .busy(b8)
  );

  uart_rx_param #(.BAUD_DIV(BD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut7 (
    .clk(clk), .rst(rst), .RX(rx7), .rx_data(d7), .rx_valid(v7), .rx_ready(rdy7),
    .frame_err(fe7), .parity_err(pe7), .overrun(ov7), .busy(b7)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    v8_q <= v8;
    if (v8 && !v8_q) t_valid <= cyc;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic b);
    if (sel == 0) rx8 = b;
    else          rx7 = b;
  endtask

  // One frame, LSB first; gbit >= 0 inverts that data bit for one mid-bit cycle.
  task automatic send(input int sel, input logic [7:0] d, input int nb, input bit par_en,
                      input bit pflip, input int nstop, input logic stopv, input int gbit);
    drive(sel, 1'b0);
    t_start = cyc;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      drive(sel, d[i]);
      if (gbit == i) begin
        repeat (8) @(negedge clk);
        drive(sel, ~d[i]);
        @(negedge clk);
        drive(sel, d[i]);
        repeat (BD - 9) @(negedge clk);
      end else begin
        repeat (BD) @(negedge clk);
      end
    end
    if (par_en) begin
      drive(sel, (^d) ^ pflip);
      repeat (BD) @(negedge clk);
    end
    for (int s = 0; s < nstop; s++) begin
      drive(sel, stopv);
      repeat (BD) @(negedge clk);
    end
  endtask

  task automatic expect_word(input int sel, input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e = '{d: d, fe: fe, pe: pe};
    if (sel == 0) q8.push_back(e);
    else          q7.push_back(e);
  endtask

  task automatic get_word(input int sel, input string tag);
    int   n;
    logic v;
    exp_t e;
    n = 0;
    v = (sel == 0) ? v8 : v7;
    while (v !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
      v = (sel == 0) ? v8 : v7;
    end
    chk({tag, "_valid"}, 32'(v), 32'd1);
    chk({tag, "_sb_pending"}, 32'((sel == 0) ? q8.size() : q7.size()), 32'd1);
    if (sel == 0 && q8.size() > 0) begin
      e = q8.pop_front();
      chk({tag, "_data"}, 32'(d8), 32'(e.d));
      chk({tag, "_frame_err"}, 32'(fe8), 32'(e.fe));
      chk({tag, "_parity_err"}, 32'(pe8), 32'(e.pe));
    end else if (sel == 1 && q7.size() > 0) begin
      e = q7.pop_front();
      chk({tag, "_data"}, 32'(d7), 32'(e.d));
      chk({tag, "_frame_err"}, 32'(fe7), 32'(e.fe));
      chk({tag, "_parity_err"}, 32'(pe7), 32'(e.pe));
    end
  endtask

  task automatic accept(input int sel, input string tag);
    if (sel == 0) rdy8 = 1'b1;
    else          rdy7 = 1'b1;
    @(negedge clk);
    rdy8 = 1'b0;
    rdy7 = 1'b0;
    chk({tag, "_valid_fall"}, 32'((sel == 0) ? v8 : v7), 32'd0);
  endtask

  initial begin
    int bcnt;
    rst  = 1'b1;
    rx8  = 1'b1;
    rx7  = 1'b1;
    rdy8 = 1'b0;
    rdy7 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(v8), 32'd0);
    chk("rst_data", 32'(d8), 32'd0);
    chk("rst_busy", 32'(b8), 32'd0);
    chk("rst_overrun", 32'(ov8), 32'd0);
    chk("rst_frame_err", 32'(fe8), 32'd0);
    chk("rst_valid7", 32'(v7), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 0xA5 with latency from the start edge
    expect_word(0, 8'hA5, 1'b0, 1'b0);
    send(0, 8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, -1);
    get_word(0, "a5");
    chk("a5_latency", 32'((t_valid - t_start) >= 150 && (t_valid - t_start) <= 160), 32'd1);
    accept(0, "a5");

    // 7E2: correct parity, then flipped parity bit
    expect_word(1, 8'h55, 1'b0, 1'b0);
    send(1, 8'h55, 7, 1'b1, 1'b0, 2, 1'b1, -1);
    get_word(1, "par_ok");
    accept(1, "par_ok");
    expect_word(1, 8'h55, 1'b0, 1'b1);
    send(1, 8'h55, 7, 1'b1, 1'b1, 2, 1'b1, -1);
    get_word(1, "par_bad");
    accept(1, "par_bad");

    // Stop bit low, line left in break
    expect_word(0, 8'h3C, 1'b1, 1'b0);
    send(0, 8'h3C, 8, 1'b0, 1'b0, 1, 1'b0, -1);
    get_word(0, "ferr");
    accept(0, "ferr");
    repeat (300) @(negedge clk);
    chk("break_no_valid", 32'(v8), 32'd0);
    chk("break_not_busy", 32'(b8), 32'd0);
    rx8 = 1'b1;
    repeat (40) @(negedge clk);
    chk("break_release_idle", 32'(b8), 32'd0);
    expect_word(0, 8'h5A, 1'b0, 1'b0);
    send(0, 8'h5A, 8, 1'b0, 1'b0, 1, 1'b1, -1);
    get_word(0, "after_break");
    accept(0, "after_break");

    // Overrun: second word dropped, first word held
    expect_word(0, 8'h11, 1'b0, 1'b0);
    send(0, 8'h11, 8, 1'b0, 1'b0, 1, 1'b1, -1);
    send(0, 8'h22, 8, 1'b0, 1'b0, 1, 1'b1, -1);
    chk("ovr_set", 32'(ov8), 32'd1);
    get_word(0, "ovr");
    accept(0, "ovr");
    chk("ovr_clear", 32'(ov8), 32'd0);

    // 4-cycle low glitch on idle line
    rx8 = 1'b0;
    repeat (4) @(negedge clk);
    rx8 = 1'b1;
    bcnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (b8) bcnt++;
    end
    chk("glitch_busy_window", 32'(bcnt >= 6 && bcnt <= 10), 32'd1);
    chk("glitch_no_valid", 32'(v8), 32'd0);

`ifdef UART_RX_MAJVOTE_EN
    expect_word(0, 8'hFF, 1'b0, 1'b0);
    send(0, 8'hFF, 8, 1'b0, 1'b0, 1, 1'b1, 3);
    get_word(0, "majvote");
    accept(0, "majvote");
`endif

    // Reset after three data bits, then a clean frame
    rx8 = 1'b0;
    repeat (BD) @(negedge clk);
    rx8 = 1'b1;
    repeat (BD) @(negedge clk);
    rx8 = 1'b0;
    repeat (2 * BD) @(negedge clk);
    chk("mid_busy", 32'(b8), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_valid", 32'(v8), 32'd0);
    chk("midrst_busy", 32'(b8), 32'd0);
    chk("midrst_data", 32'(d8), 32'd0);
    chk("midrst_overrun", 32'(ov8), 32'd0);
    rx8 = 1'b1;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("postrst_no_valid", 32'(v8), 32'd0);
    expect_word(0, 8'h81, 1'b0, 1'b0);
    send(0, 8'h81, 8, 1'b0, 1'b0, 1, 1'b1, -1);
    get_word(0, "x81");
    accept(0, "x81");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
